rsa_pre_scaler: RTL and testbench

Sequential, parametrised modular pre-scaler for the RSA/Montgomery datapath. It computes T_o = M_i * 2^k mod N_i by k iterations of modular doubling, one doubling per clock. k is selectable at run time, up to MAX_K. It runs ahead of the Montgomery multiplier to move the message into the Montgomery domain (k = WIDTH). It adds a start/busy/finish handshake and an input-range error flag.

---
 rtl/rsa_pre_scaler.sv | 156 +++++++++++++++
 tb/tb_rsa_pre_scaler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rsa_pre_scaler.sv
// Modular pre-scaler: T_o = M_i * 2^k mod N_i, one conditional-subtract doubling per clock.
// Used ahead of the Montgomery multiplier to move an operand into the Montgomery domain.
//
// state | meaning
// IDLE  | waiting for start, busy=0
// RUN   | one modular doubling per clock until k doublings are done
// DONE  | k==0 or illegal inputs; publish acc/err on the next edge
module rsa_pre_scaler #(
    parameter int WIDTH = 256,
    parameter int MAX_K = 256,
    parameter int KW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N_i,
    input  logic [WIDTH-1:0] M_i,
    input  logic [KW-1:0]    k_i,
    output logic             busy,
    output logic [WIDTH-1:0] T_o,
    output logic             finish,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [KW:0] MAX_K_L = (KW+1)'(MAX_K);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [KW-1:0]    k_q, k_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic             err_next_q, err_next_d;
    logic             err_q, err_d;
    logic             finish_q, finish_d;

    logic             in_err;
    logic             last_step;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   n_ext;
    logic [WIDTH-1:0] dbl_res;

    // acc < N always holds, so 2*acc < 2N and a single subtract brings it back in range;
    // the compare keeps the carry bit and truncation happens only after the subtract.
    always_comb begin
        in_err    = (N_i == '0) || (M_i >= N_i) || ({1'b0, k_i} > MAX_K_L);
        dbl       = {acc_q, 1'b0};
        n_ext     = {1'b0, n_q};
        dbl_res   = (dbl >= n_ext) ? WIDTH'(dbl - n_ext) : WIDTH'(dbl);
        last_step = (cnt_q == (k_q - KW'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_err || (k_i == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        T_o    = t_q;
        finish = finish_q;
        err    = err_q;
    end

    always_comb begin
        n_d        = n_q;
        k_d        = k_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        t_d        = t_q;
        err_next_d = err_next_q;
        err_d      = err_q;
        finish_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = N_i;
                    k_d   = k_i;
                    cnt_d = '0;
                    if (in_err) begin
                        err_next_d = 1'b1;
                        acc_d      = '0;
                    end else begin
                        err_next_d = 1'b0;
                        acc_d      = M_i;
                    end
                end
            end
            RUN: begin
                acc_d = dbl_res;
                cnt_d = cnt_q + KW'(1);
                if (last_step) begin
                    t_d      = dbl_res;
                    err_d    = 1'b0;
                    finish_d = 1'b1;
                end
            end
            DONE: begin
                t_d      = acc_q;
                err_d    = err_next_q;
                finish_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            t_q        <= '0;
            err_next_q <= 1'b0;
            err_q      <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            t_q        <= t_d;
            err_next_q <= err_next_d;
            err_q      <= err_d;
            finish_q   <= finish_d;
        end
    end

endmodule

// File: tb/tb_rsa_pre_scaler.sv
// Directed bench for rsa_pre_scaler: a 16-bit instance (MAX_K=16) for arithmetic
// boundaries, error cases and robustness, plus a default 256-bit instance.
module tb_rsa_pre_scaler;

    logic        clk;
    logic        rst_n;

    logic        start16;
    logic [15:0] n16, m16;
    logic [4:0]  k16;
    logic        busy16, finish16, err16;
    logic [15:0] t16;

    logic         start256;
    logic [255:0] n256, m256;
    logic [8:0]   k256;
    logic         busy256, finish256, err256;
    logic [255:0] t256;

    int checks;
    int errors;

    rsa_pre_scaler #(.WIDTH(16), .MAX_K(16), .KW(5)) u_dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start16),
        .N_i    (n16),
        .M_i    (m16),
        .k_i    (k16),
        .busy   (busy16),
        .T_o    (t16),
        .finish (finish16),
        .err    (err16)
    );

    rsa_pre_scaler u_dut256 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start256),
        .N_i    (n256),
        .M_i    (m256),
        .k_i    (k256),
        .busy   (busy256),
        .T_o    (t256),
        .finish (finish256),
        .err    (err256)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one operation on the 16-bit instance and follow it to finish.
    // With glitch=1 a second start with different inputs is pulsed mid-run.
    task automatic op16(input string tag, input logic [15:0] n, input logic [15:0] m,
                        input logic [4:0] k, input logic [15:0] exp_t, input logic exp_err,
                        input int exp_lat, input bit glitch);
        int lat;
        int bcnt;
        @(negedge clk);
        n16 = n; m16 = m; k16 = k; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!finish16 && lat < 400) begin
            if (busy16) bcnt++;
            if (glitch && lat == 1) begin
                start16 = 1'b1; n16 = 16'd7; m16 = 16'd3; k16 = 5'd2;
            end else begin
                start16 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start16 = 1'b0;
        check_val({tag, " latency"}, 256'(lat), 256'(exp_lat));
        check_val({tag, " busy_cycles"}, 256'(bcnt), 256'(exp_lat));
        check_val({tag, " T_o"}, 256'(t16), 256'(exp_t));
        check_val({tag, " err"}, 256'(err16), 256'(exp_err));
        check_val({tag, " busy_at_finish"}, 256'(busy16), 256'(0));
        @(posedge clk); #1;
        check_val({tag, " finish_one_cycle"}, 256'(finish16), 256'(0));
        check_val({tag, " T_o_held"}, 256'(t16), 256'(exp_t));
        check_val({tag, " err_held"}, 256'(err16), 256'(exp_err));
    endtask

    // b2b=1 launches in the current (finish) cycle instead of waiting for a negedge.
    task automatic op256(input string tag, input logic [255:0] n, input logic [255:0] m,
                         input logic [8:0] k, input logic [255:0] exp_t, input int exp_lat,
                         input bit b2b);
        int lat;
        if (!b2b) @(negedge clk);
        n256 = n; m256 = m; k256 = k; start256 = 1'b1;
        @(posedge clk); #1;
        start256 = 1'b0;
        lat = 0;
        while (!finish256 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, " latency"}, 256'(lat), 256'(exp_lat));
        check_val({tag, " T_o"}, t256, exp_t);
        check_val({tag, " err"}, 256'(err256), 256'(0));
    endtask

    logic [255:0] nbig;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start16 = 1'b0; n16 = '0; m16 = '0; k16 = '0;
        start256 = 1'b0; n256 = '0; m256 = '0; k256 = '0;
        nbig = '1;
        nbig = nbig - 256'd188;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset busy", 256'(busy16), 256'(0));
        check_val("reset finish", 256'(finish16), 256'(0));
        check_val("reset err", 256'(err16), 256'(0));
        check_val("reset T_o", 256'(t16), 256'(0));
        check_val("reset busy256", 256'(busy256), 256'(0));
        check_val("reset T_o256", t256, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        op16("basic",    16'd13,     16'd5,      5'd4,  16'd2,      1'b0, 4, 1'b0);
        op16("equal",    16'd10,     16'd5,      5'd1,  16'd0,      1'b0, 1, 1'b0);
        op16("carry",    16'hFFF1,   16'hFFF0,   5'd1,  16'hFFEF,   1'b0, 1, 1'b0);
        op16("m_eq_n",   16'd13,     16'd13,     5'd3,  16'd0,      1'b1, 1, 1'b0);
        op16("k_zero",   16'd13,     16'd7,      5'd0,  16'd7,      1'b0, 1, 1'b0);
        op16("n_zero",   16'd0,      16'd5,      5'd2,  16'd0,      1'b1, 1, 1'b0);
        op16("k_max",    16'd1001,   16'd1,      5'd16, 16'd471,    1'b0, 16, 1'b0);
        op16("k_over",   16'd13,     16'd5,      5'd17, 16'd0,      1'b1, 1, 1'b0);
        op16("glitch",   16'd13,     16'd5,      5'd4,  16'd2,      1'b0, 4, 1'b1);

        op256("big",  nbig, 256'd1, 9'd256, 256'd189, 256, 1'b0);
        op256("b2b",  nbig, 256'd2, 9'd1,   256'd4,   1,   1'b1);

        // Abort mid-run: outputs clear immediately and no finish follows.
        @(negedge clk);
        n16 = 16'd13; m16 = 16'd5; k16 = 5'd4; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("abort busy", 256'(busy16), 256'(0));
        check_val("abort finish", 256'(finish16), 256'(0));
        check_val("abort T_o", 256'(t16), 256'(0));
        check_val("abort err", 256'(err16), 256'(0));
        repeat (4) @(posedge clk);
        #1;
        check_val("abort no_finish", 256'(finish16), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("abort still_idle", 256'(finish16 | busy16), 256'(0));
        op16("after_abort", 16'd13, 16'd5, 5'd4, 16'd2, 1'b0, 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
